// File: rtl/cmd_encoder.sv
// Push-button front end: synchronises and debounces two raw button lines, merges
// near-simultaneous presses into code 11, and emits one command pulse per press.
module cmd_encoder #(
  parameter int DEBOUNCE  = 4,
  parameter int COMBO_WIN = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_btn,
  output logic [1:0] o_cmd,
  output logic       o_cmd_valid,
  output logic       o_busy
);

  localparam int DB_W  = (DEBOUNCE  > 1) ? $clog2(DEBOUNCE)  : 1;
  localparam int WIN_W = (COMBO_WIN > 1) ? $clog2(COMBO_WIN) : 1;
  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE - 1);
  localparam logic [WIN_W-1:0] WIN_MAX = WIN_W'(COMBO_WIN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRE  = 2'd2,
    HOLD  = 2'd3
  } stateT;

  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       w_db;
  stateT            r_state;
  stateT            w_nextState;
  logic [1:0]       r_code;
  logic [1:0]       w_nextCode;
  logic [WIN_W-1:0] r_winCnt;
  logic [WIN_W-1:0] w_nextWinCnt;
  logic [1:0]       w_acc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Each line must disagree with its debounced value for DEBOUNCE consecutive edges to flip it.
  for (genvar gi = 0; gi < 2; gi++) begin : gDebounce
    logic [DB_W-1:0] r_cnt;
    logic            r_dbBit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_cnt   <= '0;
        r_dbBit <= 1'b0;
      end else if (r_sync2[gi] == r_dbBit) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_MAX) begin
        r_dbBit <= r_sync2[gi];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_db[gi] = r_dbBit;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_code   <= 2'b00;
      r_winCnt <= '0;
    end else begin
      r_state  <= w_nextState;
      r_code   <= w_nextCode;
      r_winCnt <= w_nextWinCnt;
    end
  end

  assign w_acc = r_code | w_db;

  // ARMED gives a second button COMBO_WIN cycles to join before a single code fires.
  always_comb begin
    w_nextState  = r_state;
    w_nextCode   = r_code;
    w_nextWinCnt = r_winCnt;
    case (r_state)
      IDLE: begin
        if (w_db == 2'b11) begin
          w_nextCode  = 2'b11;
          w_nextState = FIRE;
        end else if (w_db != 2'b00) begin
          w_nextCode   = w_db;
          w_nextWinCnt = '0;
          w_nextState  = ARMED;
        end
      end
      ARMED: begin
        if (w_acc == 2'b11) begin
          w_nextCode  = 2'b11;
          w_nextState = FIRE;
        end else if ((w_db == 2'b00) || (r_winCnt == WIN_MAX)) begin
          w_nextState = FIRE;
        end else begin
          w_nextWinCnt = r_winCnt + 1'b1;
        end
      end
      FIRE: begin
        w_nextState = HOLD;
      end
      HOLD: begin
        if (w_db == 2'b00) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign o_cmd       = (r_state == FIRE) ? r_code : 2'b00;
  assign o_cmd_valid = (r_state == FIRE);
  assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_cmd_encoder.sv
// Self-checking bench for cmd_encoder: directed scenarios plus random button
// activity, compared every cycle against a look-back reference model.
module tb_cmd_encoder;

  localparam int D  = 4;
  localparam int CW = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] btn = 2'b00;
  logic [1:0] cmd;
  logic       cmdValid;
  logic       busy;

  int total = 0;
  int bad = 0;

  logic [1:0] rawHist[$];
  logic [1:0] mDb;
  logic [1:0] mCode;
  bit         mArmed;
  bit         mFiring;
  bit         mHolding;
  int         mWaited;

  int         scEdge;
  int         fireCount;
  int         firstFire;
  bit         busySeen;
  logic [1:0] fireCodes[$];

  always #5 clk = ~clk;

  cmd_encoder #(
    .DEBOUNCE (D),
    .COMBO_WIN(CW)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_btn      (btn),
    .o_cmd      (cmd),
    .o_cmd_valid(cmdValid),
    .o_busy     (busy)
  );

  // Reference state after reset: everything idle, line history all released.
  function automatic void modelReset();
    rawHist.delete();
    for (int k = 0; k < D + 2; k++) rawHist.push_back(2'b00);
    mDb      = 2'b00;
    mCode    = 2'b00;
    mArmed   = 1'b0;
    mFiring  = 1'b0;
    mHolding = 1'b0;
    mWaited  = 0;
  endfunction

  // One rising edge: the press logic reacts to the debounced value from before the edge,
  // and a debounced bit flips when the last D synchronised samples all disagreed with it.
  function automatic void modelEdge(input logic [1:0] b);
    logic [1:0] nDb;
    logic [1:0] sample;
    bit         flip;
    int         n;
    if (mFiring) begin
      mFiring  = 1'b0;
      mHolding = 1'b1;
    end else if (mHolding) begin
      if (mDb == 2'b00) mHolding = 1'b0;
    end else if (mArmed) begin
      if ((mCode | mDb) == 2'b11) begin
        mCode   = 2'b11;
        mArmed  = 1'b0;
        mFiring = 1'b1;
      end else if (mDb == 2'b00 || mWaited == CW - 1) begin
        mArmed  = 1'b0;
        mFiring = 1'b1;
      end else begin
        mWaited++;
      end
    end else if (mDb == 2'b11) begin
      mCode   = 2'b11;
      mFiring = 1'b1;
    end else if (mDb != 2'b00) begin
      mCode   = mDb;
      mArmed  = 1'b1;
      mWaited = 0;
    end

    rawHist.push_back(b);
    if (rawHist.size() > 64) void'(rawHist.pop_front());
    n   = rawHist.size();
    nDb = mDb;
    for (int i = 0; i < 2; i++) begin
      flip = 1'b1;
      for (int k = 0; k < D; k++) begin
        sample = rawHist[n - 3 - k];
        if (sample[i] == mDb[i]) flip = 1'b0;
      end
      if (flip) nDb[i] = ~mDb[i];
    end
    mDb = nDb;
  endfunction

  task automatic checkOutput(input string tag);
    logic [1:0] expCmd;
    expCmd = mFiring ? mCode : 2'b00;
    total++;
    assert (cmd === expCmd) else begin
      bad++;
      $error("[TB] FAIL %s cmd edge=%0d: got %b want %b", tag, scEdge, cmd, expCmd);
    end
    total++;
    assert (cmdValid === mFiring) else begin
      bad++;
      $error("[TB] FAIL %s cmd_valid edge=%0d: got %b want %b", tag, scEdge, cmdValid, mFiring);
    end
    total++;
    assert (busy === (mArmed | mFiring | mHolding)) else begin
      bad++;
      $error("[TB] FAIL %s busy edge=%0d: got %b want %b", tag, scEdge, busy,
             (mArmed | mFiring | mHolding));
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [1:0] b, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      btn = b;
      @(posedge clk);
      if (rst_n) modelEdge(b);
      else modelReset();
      #1;
      checkOutput(tag);
      if (busy) busySeen = 1'b1;
      if (cmdValid) begin
        fireCount++;
        if (firstFire < 0) firstFire = scEdge;
        fireCodes.push_back(cmd);
      end
      scEdge++;
    end
  endtask

  task automatic startScenario();
    scEdge    = 0;
    fireCount = 0;
    firstFire = -1;
    busySeen  = 1'b0;
    fireCodes.delete();
  endtask

  task automatic checkScenario(input string tag, input int expCount, input int expFirst,
                               input logic [1:0] expCode);
    total++;
    assert (fireCount === expCount) else begin
      bad++;
      $error("[TB] FAIL %s pulse count: got %0d want %0d", tag, fireCount, expCount);
    end
    if (expCount > 0) begin
      total++;
      assert (firstFire === expFirst) else begin
        bad++;
        $error("[TB] FAIL %s first pulse edge: got %0d want %0d", tag, firstFire, expFirst);
      end
      total++;
      assert (fireCodes.size() > 0 && fireCodes[0] === expCode) else begin
        bad++;
        $error("[TB] FAIL %s first code: got %b want %b", tag,
               (fireCodes.size() > 0) ? fireCodes[0] : 2'bxx, expCode);
      end
    end
  endtask

  initial begin
    modelReset();
    $display("[TB] reset with random buttons");
    startScenario();
    for (int c = 0; c < 3; c++) applyStimulus("reset", 2'($urandom_range(0, 3)), 1);
    rst_n = 1'b1;
    applyStimulus("reset", 2'b00, 20);
    checkScenario("reset", 0, 0, 2'b00);
    total++;
    assert (busySeen === 1'b0) else begin
      bad++;
      $error("[TB] FAIL reset busy seen: got %b want 0", busySeen);
    end

    $display("[TB] single press");
    startScenario();
    applyStimulus("single", 2'b01, 30);
    applyStimulus("single", 2'b00, 12);
    checkScenario("single", 1, 9, 2'b01);

    $display("[TB] combination press");
    startScenario();
    applyStimulus("combo", 2'b01, 1);
    applyStimulus("combo", 2'b11, 20);
    applyStimulus("combo", 2'b00, 12);
    checkScenario("combo", 1, 7, 2'b11);

    $display("[TB] glitch rejection");
    startScenario();
    applyStimulus("glitch3", 2'b10, 3);
    applyStimulus("glitch3", 2'b00, 15);
    checkScenario("glitch3", 0, 0, 2'b00);
    total++;
    assert (busySeen === 1'b0) else begin
      bad++;
      $error("[TB] FAIL glitch3 busy seen: got %b want 0", busySeen);
    end
    startScenario();
    applyStimulus("pulse4", 2'b10, 4);
    applyStimulus("pulse4", 2'b00, 15);
    checkScenario("pulse4", 1, 9, 2'b10);

    $display("[TB] hold and re-press");
    startScenario();
    applyStimulus("repress", 2'b01, 40);
    applyStimulus("repress", 2'b00, 10);
    applyStimulus("repress", 2'b10, 30);
    applyStimulus("repress", 2'b00, 12);
    checkScenario("repress", 2, 9, 2'b01);
    total++;
    assert (fireCodes.size() == 2 && fireCodes[1] === 2'b10) else begin
      bad++;
      $error("[TB] FAIL repress second code: got %b want 10",
             (fireCodes.size() > 1) ? fireCodes[1] : 2'bxx);
    end

    $display("[TB] reset while armed");
    startScenario();
    applyStimulus("midreset", 2'b01, 8);
    total++;
    assert (busy === 1'b1) else begin
      bad++;
      $error("[TB] FAIL midreset armed before reset: got busy=%b want 1", busy);
    end
    #1;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("midreset-async");
    applyStimulus("midreset", 2'b01, 2);
    rst_n = 1'b1;
    startScenario();
    applyStimulus("restart", 2'b01, 15);
    applyStimulus("restart", 2'b00, 12);
    checkScenario("restart", 1, 9, 2'b01);

    $display("[TB] random activity");
    startScenario();
    for (int s = 0; s < 40; s++) begin
      applyStimulus("random", 2'($urandom_range(0, 3)), $urandom_range(1, 12));
    end
    applyStimulus("random", 2'b00, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmd_encoder.md
# cmd_encoder

Front-end stage that turns two raw, asynchronous push-button lines into clean 2-bit command codes for the downstream Moore controller's `in[1:0]` port. It synchronises and debounces each line, merges near-simultaneous presses into a combination code, and emits exactly one non-idle code per press. Code 2'b00 is the idle code; 01, 10 and 11 are commands.

## Interface
- `DEBOUNCE`, default 4: number of consecutive sampling edges a synchronised line must differ from its debounced value before that value flips. Legal range ≥1.
- `COMBO_WIN`, default 3: number of cycles the block waits in ARMED for a second button before firing a single-button code. Legal range ≥1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `btn`  in  2  raw button lines, asynchronous to `clk`; 1 = pressed.
- `cmd`  out  2  command code to the downstream controller; 2'b00 except during a FIRE cycle.
- `cmd_valid`  out  1  high exactly during a FIRE cycle.
- `busy`  out  1  high in ARMED, FIRE and HOLD.

## Operation
- Synchroniser: two flops per bit; `sync2` is the second stage. Resets to 0.
- Debounce, per bit, with a counter of width clog2(DEBOUNCE) (minimum 1) and a flop `db[i]`:
  - If `sync2[i]` == `db[i]`, the counter clears.
  - Otherwise, if the counter == DEBOUNCE-1, `db[i]` takes `sync2[i]` and the counter clears; if not, the counter increments.
  - Both counter and `db` reset to 0.
- FSM states: IDLE, ARMED, FIRE, HOLD. `code` is a 2-bit register.
  - IDLE:
    - If `db` == 11, load `code` = 11 and go to FIRE.
    - Else if `db` ≠ 00, load `code` = `db`, clear `win_cnt` and go to ARMED.
    - Otherwise stay in IDLE.
  - ARMED:
    - Compute `acc` = `code` | `db`.
    - If `acc` == 11, load `code` = 11 and go to FIRE.
    - Else if `db` == 00 (early release) or `win_cnt` == COMBO_WIN-1, go to FIRE with `code` unchanged.
    - Otherwise increment `win_cnt`.
  - FIRE: lasts exactly one cycle, then go to HOLD.
  - HOLD: stay until `db` == 00, then go to IDLE. No command repeats while any button is held.
- Outputs decode from registered state only, so they are glitch-free.
  - `cmd` = `code` when state == FIRE, else 00.
  - `cmd_valid` = (state == FIRE).
  - `busy` = (state ≠ IDLE).
- A one-cycle pulse with `cmd` ≠ 00 makes the downstream controller advance exactly once. Idle 00 holds it in its waiting states.

## Timing
- Reset values: state IDLE, `code` 00, `win_cnt` 0, sync and debounce flops 0. Outputs: `cmd` = 00, `cmd_valid` = 0, `busy` = 0.
- Asserting `reset` mid-operation, including in ARMED or FIRE, forces all outputs to 0 asynchronously. A FIRE cycle cut by reset is lost and is not replayed.
- Edge numbering: edge 0 is the first rising edge that samples a new raw level. That level must be held through edge DEBOUNCE-1.
  - `db` flips at edge DEBOUNCE+1.
  - A raw pulse held for DEBOUNCE-1 or fewer edges never changes `db`.
- Single button, no second press: ARMED from edge D+2, FIRE from edge D+2+COMBO_WIN. `cmd` is valid for that one cycle (D = DEBOUNCE).
- Second button whose `db` rises while in ARMED: FIRE at the next edge with `code` 11.
- Both `db` bits rising on the same edge: IDLE goes directly to FIRE with `code` 11, one edge after the `db` change.
- Early release in ARMED (`db` returns to 00): FIRE at the next edge with the latched single code, then HOLD, then IDLE one edge later.
- `db` switching 01→10 on one edge while in ARMED: `acc` = 11, so the block fires 11.
- `win_cnt` never exceeds COMBO_WIN-1 and has no wrap path.

## Test plan
All scenarios use DEBOUNCE=4 and COMBO_WIN=3.
- Reset: hold `reset`=0 for 3 cycles with random `btn`, then release with `btn`=00 → `cmd`=00, `cmd_valid`=0, `busy`=0 throughout; no pulse for 20 cycles.
- Single press: `btn`=01 from edge 0, held 30 cycles → `busy` rises after edge 6; exactly one `cmd`=01, `cmd_valid`=1 cycle following edge 9; then 00 until release, and `busy` falls 7 edges after release.
- Combination: `btn[0]` rises at edge 0, `btn[1]` at edge 1 → single `cmd`=11 pulse following edge 7; no 01 or 10 pulse ever appears.
- Glitch rejection: `btn`=10 for 3 cycles, then 00 → no `cmd_valid`, `busy` stays 0. Repeating with a 4-cycle pulse → `cmd`=10 pulse, via the early-release path or after COMBO_WIN.
- Hold and re-press: press 01 and hold 40 cycles, then release for 10 cycles, then press 10 and hold → exactly two pulses, 01 then 10; none while held.
- Reset mid-ARMED: press 01, assert `reset` at edge 7 for 2 cycles → outputs go 0 at once; after release with `btn` still 01, a new press sequence restarts and 01 fires 9 edges after the first post-reset sampling edge.
